// File: rtl/image_stream_ctrl.sv
// Streams stored image frames byte-by-byte to a classifier and captures its result
// once per frame; image selection advances on a button edge or a dwell timer.
module image_stream_ctrl #(
  parameter int BYTES_PER_IMAGE = 32,
  parameter int NUM_IMAGES      = 4,
  parameter int DATA_W          = 8,
  parameter int RESULT_W        = 4,
  parameter int SAMPLE_OFFSET   = 16,
  parameter int DWELL_CYCLES    = 12000000,
  localparam int ADDR_W  = $clog2(NUM_IMAGES * BYTES_PER_IMAGE),
  localparam int IMG_W   = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int BYTE_W  = $clog2(BYTES_PER_IMAGE),
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                next_img,
  input  logic                auto_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   stream_data,
  output logic                frame_start,
  input  logic [RESULT_W-1:0] result_in,
  output logic [RESULT_W-1:0] result_out,
  output logic                result_valid,
  output logic [IMG_W-1:0]    img_index
);

  typedef enum logic {FILL, RUN} state_t;

  logic [DATA_W-1:0]   mem_q [NUM_IMAGES * BYTES_PER_IMAGE];
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [IMG_W-1:0]    img_q, img_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                pend_q, pend_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic [DATA_W-1:0]   stream_q;
  logic                fs_q;
  logic [RESULT_W-1:0] result_q, result_d;
  state_t              state_q, state_d;

  logic [ADDR_W-1:0]   rdAddr;
  logic                lastByte, commit, sample, btnEdge, dwellWrap;

  // Memory has no reset so its contents survive RST; combinational read gives old data on a same-cycle write.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rdAddr    = ADDR_W'(img_q * BYTES_PER_IMAGE) + ADDR_W'(byte_q);
  assign lastByte  = (byte_q == BYTE_W'(BYTES_PER_IMAGE - 1));
  assign commit    = lastByte && pend_q;
  assign sample    = (byte_q == BYTE_W'(SAMPLE_OFFSET)) && !commit;
  assign btnEdge   = sync2_q && !sync3_q;
  assign dwellWrap = auto_en && (dwell_q == DWELL_W'(DWELL_CYCLES - 1));

  always_comb begin
    byte_d  = lastByte ? '0 : byte_q + BYTE_W'(1);
    img_d   = img_q;
    if (commit) img_d = (img_q == IMG_W'(NUM_IMAGES - 1)) ? '0 : img_q + IMG_W'(1);
    // A request arriving in the commit cycle is kept for the next frame boundary.
    pend_d  = (pend_q && !commit) || btnEdge || dwellWrap;
    dwell_d = (!auto_en || commit || dwellWrap) ? '0 : dwell_q + DWELL_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (commit) begin
      state_d = FILL;
    end else if (sample) begin
      result_d = result_in;
      state_d  = RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_q   <= '0;
      img_q    <= '0;
      dwell_q  <= '0;
      pend_q   <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      stream_q <= '0;
      fs_q     <= 1'b0;
      result_q <= '0;
      state_q  <= FILL;
    end else begin
      byte_q   <= byte_d;
      img_q    <= img_d;
      dwell_q  <= dwell_d;
      pend_q   <= pend_d;
      sync1_q  <= next_img;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      stream_q <= mem_q[rdAddr];
      fs_q     <= (byte_q == '0);
      result_q <= result_d;
      state_q  <= state_d;
    end
  end

  assign stream_data  = stream_q;
  assign frame_start  = fs_q;
  assign result_out   = result_q;
  assign result_valid = (state_q == RUN);
  assign img_index    = img_q;

endmodule

// File: tb/tb_image_stream_ctrl.sv
// Self-checking bench for image_stream_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_image_stream_ctrl;
  localparam int BPI   = 32;
  localparam int NIMG  = 4;
  localparam int SO    = 16;
  localparam int DWELL = 100;

  logic       CLK, RST, next_img, auto_en, wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, stream_data;
  logic       frame_start, result_valid;
  logic [3:0] result_in, result_out;
  logic [1:0] img_index;

  image_stream_ctrl #(
    .BYTES_PER_IMAGE(BPI), .NUM_IMAGES(NIMG), .DATA_W(8), .RESULT_W(4),
    .SAMPLE_OFFSET(SO), .DWELL_CYCLES(DWELL)
  ) dut (
    .CLK(CLK), .RST(RST), .next_img(next_img), .auto_en(auto_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stream_data(stream_data), .frame_start(frame_start), .result_in(result_in),
    .result_out(result_out), .result_valid(result_valid), .img_index(img_index)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: frame position is cycles-since-reset modulo BPI; a button rise is seen two clocks late.
  logic [7:0] mMem [BPI*NIMG];
  int         cyc = 0;
  int         mImg = 0;
  int         mDwell = 0;
  bit         mPend = 1'b0;
  bit         h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic [7:0] eStream = '0;
  bit         eFs = 1'b0;
  logic [3:0] eRes = '0;
  bit         eValid = 1'b0;

  task automatic modelReset();
    cyc = 0; mImg = 0; mDwell = 0; mPend = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    eStream = '0; eFs = 1'b0; eRes = '0; eValid = 1'b0;
  endtask

  task automatic modelStep();
    int b;
    bit rise, timerDue, boundary;
    b        = cyc % BPI;
    rise     = h2 && !h3;
    timerDue = auto_en && (mDwell == DWELL - 1);
    boundary = (b == BPI - 1) && mPend;
    eStream  = mMem[mImg * BPI + b];
    eFs      = (b == 0);
    if (b == SO && !boundary) begin
      eRes   = result_in;
      eValid = 1'b1;
    end
    if (boundary) begin
      mImg   = (mImg + 1) % NIMG;
      eValid = 1'b0;
    end
    mPend  = (mPend && !boundary) || rise || timerDue;
    mDwell = (!auto_en || boundary || timerDue) ? 0 : mDwell + 1;
    h3 = h2; h2 = h1; h1 = next_img;
    cyc++;
  endtask

  always @(posedge CLK) begin
    if (RST) modelReset();
    else modelStep();
    if (wr_en) mMem[wr_addr] = wr_data;
  end

  always @(posedge RST) modelReset();

  always @(negedge CLK) begin
    if (checkOn) begin
      checkOutput("stream_data", 32'(stream_data), 32'(eStream));
      checkOutput("frame_start", 32'(frame_start), 32'(eFs));
      checkOutput("img_index", 32'(img_index), 32'(mImg));
      checkOutput("result_out", 32'(result_out), 32'(eRes));
      checkOutput("result_valid", 32'(result_valid), 32'(eValid));
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic waitByte(input int target);
    int n;
    n = 0;
    while ((cyc % BPI) != target && n < 4 * BPI) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 4 * BPI) checkOutput("wait_byte_timeout", 32'(n), 32'(0));
  endtask

  task automatic pulseNext();
    next_img = 1'b1;
    applyStimulus(3);
    next_img = 1'b0;
    applyStimulus(3);
  endtask

  task automatic gotoImage(input int target);
    for (int k = 0; k < 2 * NIMG && mImg != target; k++) begin
      waitByte(2);
      pulseNext();
      applyStimulus(2 * BPI);
    end
    checkOutput("goto_image", 32'(img_index), 32'(target));
  endtask

  int savedImg;

  initial begin
    RST = 1'b1; next_img = 1'b0; auto_en = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; result_in = '0;

    // Load image 0 with its byte index and the others with random data while held in reset.
    for (int i = 0; i < BPI * NIMG; i++) begin
      @(negedge CLK);
      wr_en   = 1'b1;
      wr_addr = 7'(i);
      wr_data = (i < BPI) ? 8'(i) : 8'($urandom_range(0, 255));
    end
    @(negedge CLK);
    wr_en = 1'b0;
    checkOn = 1'b1;
    applyStimulus(2);
    RST = 1'b0;

    result_in = 4'd7;
    applyStimulus(3 * BPI);

    // Same-cycle write and read of the byte about to stream: old data now, new data next frame.
    wr_en   = 1'b1;
    wr_addr = 7'(mImg * BPI + (cyc % BPI));
    wr_data = 8'hA5;
    @(negedge CLK);
    wr_en = 1'b0;
    applyStimulus(2 * BPI);

    waitByte(5);
    pulseNext();
    applyStimulus(3 * BPI);

    gotoImage(3);
    savedImg = mImg;
    waitByte(2);
    pulseNext();
    pulseNext();
    pulseNext();
    applyStimulus(2 * BPI);
    checkOutput("single_increment", 32'(img_index), 32'((savedImg + 1) % NIMG));

    auto_en = 1'b1;
    applyStimulus(350);
    auto_en = 1'b0;
    applyStimulus(BPI);
    savedImg = mImg;
    applyStimulus(300);
    checkOutput("no_auto_advance", 32'(img_index), 32'(savedImg));

    gotoImage(2);
    waitByte(21);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checkOutput("async_stream", 32'(stream_data), 32'(0));
    checkOutput("async_fs", 32'(frame_start), 32'(0));
    checkOutput("async_img", 32'(img_index), 32'(0));
    checkOutput("async_res", 32'(result_out), 32'(0));
    checkOutput("async_valid", 32'(result_valid), 32'(0));
    applyStimulus(2);
    RST = 1'b0;
    applyStimulus(2 * BPI);

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      result_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) next_img = ~next_img;
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 7'($urandom_range(0, BPI * NIMG - 1));
      wr_data = 8'($urandom_range(0, 255));
    end
    wr_en = 1'b0;
    applyStimulus(4);

    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
